// File: rtl/player_bullet.sv
// Player projectile: fire-edge launch, per-frame climb, per-clock box collision
// against an enemy array, registered hit/miss pulses, saturating score and cooldown.

module player_bullet_box (
    input  logic [10:0] bl_i,
    input  logic [10:0] br_i,
    input  logic [10:0] bt_i,
    input  logic [10:0] bb_i,
    input  logic [9:0]  left_i,
    input  logic [9:0]  right_i,
    input  logic [9:0]  top_i,
    input  logic [9:0]  bot_i,
    input  logic        dead_i,
    output logic        ovl_o
);
    assign ovl_o = ~dead_i
                 && (bl_i <= {1'b0, right_i}) && (br_i >= {1'b0, left_i})
                 && (bt_i <= {1'b0, bot_i})   && (bb_i >= {1'b0, top_i});
endmodule

module player_bullet #(
    parameter int         num_enemy_p       = 4,
    parameter logic [9:0] speed_p           = 10'd8,
    parameter logic [9:0] bullet_w_p        = 10'd2,
    parameter logic [9:0] bullet_h_p        = 10'd8,
    parameter logic [9:0] top_limit_p       = 10'd0,
    parameter logic [7:0] cooldown_frames_p = 8'd30
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      frame_i,
    input  logic                      fire_i,
    input  logic [9:0]                player_left_i,
    input  logic [9:0]                player_top_i,
    input  logic [10*num_enemy_p-1:0] enemy_left_i,
    input  logic [10*num_enemy_p-1:0] enemy_right_i,
    input  logic [10*num_enemy_p-1:0] enemy_top_i,
    input  logic [10*num_enemy_p-1:0] enemy_bot_i,
    input  logic [num_enemy_p-1:0]    enemy_dead_i,
    output logic                      bullet_active_o,
    output logic [9:0]                bullet_left_o,
    output logic [9:0]                bullet_top_o,
    output logic [num_enemy_p-1:0]    hit_o,
    output logic                      miss_o,
    output logic [15:0]               score_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1, COOLDOWN = 2'd2} state_e;

    localparam logic [10:0] W11  = {1'b0, bullet_w_p};
    localparam logic [10:0] H11  = {1'b0, bullet_h_p};
    localparam logic [10:0] SP11 = {1'b0, speed_p};
    localparam logic [10:0] TL11 = {1'b0, top_limit_p};
    localparam logic [7:0]  CD_LAST = cooldown_frames_p - 8'd1;

    state_e                 state_q, state_d;
    logic                   fire_q;
    logic [9:0]             left_q, left_d, top_q, top_d;
    logic [num_enemy_p-1:0] hit_q, hit_d, ovl, hit_sel;
    logic                   miss_q, miss_d;
    logic [15:0]            score_q, score_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   fire_rise, launch_ok, at_top, any_hit, cd_done, found;
    logic [10:0]            bl, br, bt, bb;

    assign fire_rise = fire_i & ~fire_q;
    assign launch_ok = {1'b0, player_top_i} >= TL11 + H11;
    assign at_top    = {1'b0, top_q} < TL11 + SP11;
    assign cd_done   = (cooldown_frames_p == 8'd0) || (frame_i && cnt_q == CD_LAST);

    // 11-bit extents so right/bottom edges near 1023 never wrap
    assign bl = {1'b0, left_q};
    assign br = bl + W11 - 11'd1;
    assign bt = {1'b0, top_q};
    assign bb = bt + H11 - 11'd1;

    for (genvar i = 0; i < num_enemy_p; i++) begin : g_box
        player_bullet_box u_box (
            .bl_i    (bl),
            .br_i    (br),
            .bt_i    (bt),
            .bb_i    (bb),
            .left_i  (enemy_left_i[10*i +: 10]),
            .right_i (enemy_right_i[10*i +: 10]),
            .top_i   (enemy_top_i[10*i +: 10]),
            .bot_i   (enemy_bot_i[10*i +: 10]),
            .dead_i  (enemy_dead_i[i]),
            .ovl_o   (ovl[i])
        );
    end

    // Lowest index wins when several boxes overlap
    always_comb begin
        hit_sel = '0;
        found   = 1'b0;
        for (int i = 0; i < num_enemy_p; i++) begin
            if (ovl[i] && !found) begin
                hit_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end
    assign any_hit = found;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (fire_rise && launch_ok) state_d = FLYING;
            FLYING: begin
                if (any_hit)                 state_d = COOLDOWN;
                else if (frame_i && at_top)  state_d = IDLE;
            end
            COOLDOWN: if (cd_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        left_d  = left_q;
        top_d   = top_q;
        hit_d   = '0;
        miss_d  = 1'b0;
        score_d = score_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (fire_rise && launch_ok) begin
                    left_d = player_left_i;
                    top_d  = player_top_i - bullet_h_p;
                end
            end
            FLYING: begin
                if (any_hit) begin
                    hit_d   = hit_sel;
                    score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                    cnt_d   = 8'd0;
                end else if (frame_i) begin
                    if (at_top) miss_d = 1'b1;
                    else        top_d  = top_q - speed_p;
                end
            end
            COOLDOWN: if (frame_i) cnt_d = cnt_q + 8'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fire_q  <= 1'b0;
            left_q  <= '0;
            top_q   <= '0;
            hit_q   <= '0;
            miss_q  <= 1'b0;
            score_q <= '0;
            cnt_q   <= '0;
        end else begin
            fire_q  <= fire_i;
            left_q  <= left_d;
            top_q   <= top_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bullet_active_o = (state_q == FLYING);
    assign bullet_left_o   = left_q;
    assign bullet_top_o    = top_q;
    assign hit_o           = hit_q;
    assign miss_o          = miss_q;
    assign score_o         = score_q;
endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: launch, simultaneous hit/frame, miss,
// priority hits, cooldown window and asynchronous reset mid-flight.

module tb_player_bullet;
    logic        clk_i = 1'b0;
    logic        reset_ni, frame_i, fire_i;
    logic [9:0]  player_left_i, player_top_i;
    logic [39:0] enemy_left_i, enemy_right_i, enemy_top_i, enemy_bot_i;
    logic [3:0]  enemy_dead_i;
    logic        bullet_active_o, miss_o;
    logic [9:0]  bullet_left_o, bullet_top_o;
    logic [3:0]  hit_o;
    logic [15:0] score_o;
    int          checks = 0, failures = 0;

    always #5 clk_i = ~clk_i;

    player_bullet dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .frame_i(frame_i), .fire_i(fire_i),
        .player_left_i(player_left_i), .player_top_i(player_top_i),
        .enemy_left_i(enemy_left_i), .enemy_right_i(enemy_right_i),
        .enemy_top_i(enemy_top_i), .enemy_bot_i(enemy_bot_i),
        .enemy_dead_i(enemy_dead_i), .bullet_active_o(bullet_active_o),
        .bullet_left_o(bullet_left_o), .bullet_top_o(bullet_top_o),
        .hit_o(hit_o), .miss_o(miss_o), .score_o(score_o)
    );

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic frame_pulse();
        frame_i = 1'b1; tick(); frame_i = 1'b0;
    endtask

    task automatic set_enemy(input int i, input logic [9:0] l, r, t, b);
        enemy_left_i[10*i +: 10] = l; enemy_right_i[10*i +: 10] = r;
        enemy_top_i[10*i +: 10]  = t; enemy_bot_i[10*i +: 10]   = b;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0; fire_i = 1'b0; frame_i = 1'b0;
        tick(); tick();
        reset_ni = 1'b1; tick();
    endtask

    task automatic test_reset();
        player_left_i = 10'd300; player_top_i = 10'd440;
        enemy_left_i = '0; enemy_right_i = '0; enemy_top_i = '0; enemy_bot_i = '0;
        enemy_dead_i = 4'hF;
        do_reset();
        checks++; if ({bullet_active_o, bullet_left_o, bullet_top_o, hit_o, miss_o, score_o} !== 42'd0) begin
            $display("FAIL reset_outputs act=%0b left=%0d top=%0d hit=%b miss=%0b score=%0d want all 0",
                     bullet_active_o, bullet_left_o, bullet_top_o, hit_o, miss_o, score_o); failures++; end
    endtask

    task automatic test_launch_and_simul();
        fire_i = 1'b1; tick();
        checks++; if ({bullet_active_o, bullet_left_o, bullet_top_o} !== {1'b1, 10'd300, 10'd432}) begin
            $display("FAIL launch act=%0b left=%0d top=%0d want 1/300/432", bullet_active_o, bullet_left_o, bullet_top_o); failures++; end
        for (int k = 0; k < 3; k++) frame_pulse();
        checks++; if (bullet_top_o !== 10'd408) begin
            $display("FAIL climb3 top=%0d want 408", bullet_top_o); failures++; end
        // enemy 0 becomes live under the bullet in the same cycle as a frame pulse
        set_enemy(0, 10'd290, 10'd310, 10'd400, 10'd420);
        enemy_dead_i = 4'b1110; frame_i = 1'b1; tick(); frame_i = 1'b0;
        checks++; if ({hit_o, bullet_top_o, bullet_active_o, score_o} !== {4'b0001, 10'd408, 1'b0, 16'd1}) begin
            $display("FAIL simul_hit hit=%b top=%0d act=%0b score=%0d want 0001/408/0/1", hit_o, bullet_top_o, bullet_active_o, score_o); failures++; end
        enemy_dead_i = 4'hF; tick();
        checks++; if (hit_o !== 4'b0000) begin
            $display("FAIL simul_hit_once hit=%b want 0000", hit_o); failures++; end
        for (int k = 0; k < 30; k++) frame_pulse();
        tick(); tick();
        checks++; if (bullet_active_o !== 1'b0) begin
            $display("FAIL held_fire_relaunch act=%0b want 0", bullet_active_o); failures++; end
        fire_i = 1'b0; tick();
    endtask

    task automatic test_miss();
        do_reset();
        player_left_i = 10'd100; player_top_i = 10'd4;
        fire_i = 1'b1; tick(); fire_i = 1'b0;
        checks++; if (bullet_active_o !== 1'b0) begin
            $display("FAIL fire_too_high act=%0b want 0", bullet_active_o); failures++; end
        tick();
        player_top_i = 10'd40;
        fire_i = 1'b1; tick(); fire_i = 1'b0;
        checks++; if ({bullet_active_o, bullet_top_o} !== {1'b1, 10'd32}) begin
            $display("FAIL miss_launch act=%0b top=%0d want 1/32", bullet_active_o, bullet_top_o); failures++; end
        for (int k = 1; k <= 4; k++) begin
            frame_pulse();
            checks++; if (bullet_top_o !== 10'(32 - 8*k)) begin
                $display("FAIL miss_climb%0d top=%0d want %0d", k, bullet_top_o, 32 - 8*k); failures++; end
        end
        frame_pulse();
        checks++; if ({miss_o, bullet_active_o, hit_o, score_o} !== {1'b1, 1'b0, 4'b0, 16'd0}) begin
            $display("FAIL miss_pulse miss=%0b act=%0b hit=%b score=%0d want 1/0/0000/0", miss_o, bullet_active_o, hit_o, score_o); failures++; end
        tick();
        checks++; if (miss_o !== 1'b0) begin
            $display("FAIL miss_once miss=%0b want 0", miss_o); failures++; end
    endtask

    task automatic test_hit_priority();
        do_reset();
        player_left_i = 10'd300; player_top_i = 10'd440;
        set_enemy(1, 10'd296, 10'd336, 10'd100, 10'd110);
        set_enemy(2, 10'd296, 10'd336, 10'd100, 10'd110);
        for (int pass = 0; pass < 2; pass++) begin
            enemy_dead_i = (pass == 0) ? 4'b1001 : 4'b1011;
            fire_i = 1'b1; tick(); fire_i = 1'b0;
            for (int k = 0; k < 40; k++) frame_pulse();
            checks++; if ({bullet_top_o, hit_o} !== {10'd112, 4'b0}) begin
                $display("FAIL prio%0d_at112 top=%0d hit=%b want 112/0000", pass, bullet_top_o, hit_o); failures++; end
            frame_pulse();
            checks++; if ({bullet_top_o, hit_o, bullet_active_o} !== {10'd104, 4'b0, 1'b1}) begin
                $display("FAIL prio%0d_at104 top=%0d hit=%b act=%0b want 104/0000/1", pass, bullet_top_o, hit_o, bullet_active_o); failures++; end
            tick();
            checks++; if ({hit_o, score_o, bullet_active_o} !== {((pass == 0) ? 4'b0010 : 4'b0100), 16'(pass + 1), 1'b0}) begin
                $display("FAIL prio%0d_hit hit=%b score=%0d act=%0b want %b/%0d/0", pass, hit_o, score_o, bullet_active_o,
                         (pass == 0) ? 4'b0010 : 4'b0100, pass + 1); failures++; end
            tick();
            checks++; if (hit_o !== 4'b0) begin
                $display("FAIL prio%0d_hit_once hit=%b want 0000", pass, hit_o); failures++; end
            if (pass == 0) for (int k = 0; k < 30; k++) frame_pulse();
        end
    endtask

    task automatic test_cooldown();
        for (int f = 1; f <= 30; f++) begin
            frame_pulse();
            if (f == 5 || f == 29) begin
                fire_i = 1'b1; tick(); fire_i = 1'b0; tick();
                checks++; if (bullet_active_o !== 1'b0) begin
                    $display("FAIL cooldown_fire_f%0d act=%0b want 0", f, bullet_active_o); failures++; end
            end
        end
        fire_i = 1'b1; tick();
        checks++; if ({bullet_active_o, bullet_top_o} !== {1'b1, 10'd432}) begin
            $display("FAIL cooldown_relaunch act=%0b top=%0d want 1/432", bullet_active_o, bullet_top_o); failures++; end
    endtask

    task automatic test_async_reset();
        enemy_dead_i = 4'hF;
        for (int k = 0; k < 29; k++) frame_pulse();
        checks++; if (bullet_top_o !== 10'd200) begin
            $display("FAIL pre_reset_top top=%0d want 200", bullet_top_o); failures++; end
        #2 reset_ni = 1'b0; fire_i = 1'b0;
        #1;
        checks++; if ({bullet_active_o, bullet_left_o, bullet_top_o, hit_o, miss_o, score_o} !== 42'd0) begin
            $display("FAIL async_reset act=%0b left=%0d top=%0d hit=%b miss=%0b score=%0d want all 0",
                     bullet_active_o, bullet_left_o, bullet_top_o, hit_o, miss_o, score_o); failures++; end
        @(posedge clk_i); #2 reset_ni = 1'b1;
        tick();
        checks++; if ({hit_o, miss_o, bullet_active_o} !== 6'd0) begin
            $display("FAIL post_reset_idle hit=%b miss=%0b act=%0b want 0", hit_o, miss_o, bullet_active_o); failures++; end
        fire_i = 1'b1; tick(); fire_i = 1'b0;
        checks++; if ({bullet_active_o, bullet_left_o, bullet_top_o, score_o} !== {1'b1, 10'd300, 10'd432, 16'd0}) begin
            $display("FAIL post_reset_launch act=%0b left=%0d top=%0d score=%0d want 1/300/432/0",
                     bullet_active_o, bullet_left_o, bullet_top_o, score_o); failures++; end
    endtask

    initial begin
        test_reset();
        test_launch_and_simul();
        test_miss();
        test_hit_priority();
        test_cooldown();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/player_bullet.md
Name: player_bullet

Overview:
- Player-side projectile and collision responder; the source of each enemy's hit_i.
- One player bullet: launched from the player ship, moves upward once per frame, and is tested every clock against the bounding boxes of num_enemy_p enemies.
- On overlap it issues a one-cycle one-hot hit pulse to the struck enemy, bumps the score, then enters a frame-counted cooldown.
- Sits between the player ship, the enemy array and the VGA pixel mixer.

Parameters:
num_enemy_p, 4, number of enemy boxes checked
speed_p, 10'd8, pixels moved upward per frame_i
bullet_w_p, 10'd2, bullet width in pixels
bullet_h_p, 10'd8, bullet height in pixels
top_limit_p, 10'd0, topmost legal bullet row
cooldown_frames_p, 8'd30, frames after a hit before the next fire is accepted

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
frame_i  in  1  one-cycle pulse per processed frame
fire_i  in  1  fire button level; launch only on its rising edge
player_left_i  in  10  player ship left x
player_top_i  in  10  player ship top y
enemy_left_i  in  10*num_enemy_p  packed, enemy i at [10i+9:10i]
enemy_right_i  in  10*num_enemy_p  packed
enemy_top_i  in  10*num_enemy_p  packed, top <= bot, y grows downward
enemy_bot_i  in  10*num_enemy_p  packed
enemy_dead_i  in  num_enemy_p  enemy i dead, excluded from collision
bullet_active_o  out  1  bullet visible / in flight
bullet_left_o  out  10  bullet left x
bullet_top_o  out  10  bullet top y
hit_o  out  num_enemy_p  one-hot one-cycle hit pulse
miss_o  out  1  one-cycle pulse when bullet leaves the top
score_o  out  16  hit count, saturates at 16'hFFFF

Behaviour:
- Reset (async, reset_ni=0): state IDLE; all outputs 0; cooldown counter 0; fire edge register 0. A reset mid-flight kills the bullet immediately with no hit and no miss pulse.
- Fire edge detection: fire_rise = fire_i & ~fire_q, with fire_q registered every cycle in all states.
- State IDLE:
  - bullet_active_o=0.
  - On fire_rise: bullet_left_o <= player_left_i; bullet_top_o <= player_top_i - bullet_h_p; go FLYING next cycle.
  - If player_top_i < top_limit_p + bullet_h_p, the fire is ignored.
- State FLYING:
  - bullet_active_o=1.
  - Every cycle, compute overlap for each i with ~enemy_dead_i[i]. Overlap requires all four conditions:
    - bullet_left <= right_i
    - bullet_left + bullet_w_p - 1 >= left_i
    - bullet_top <= bot_i
    - bullet_top + bullet_h_p - 1 >= top_i
  - Comparisons use 11-bit arithmetic (no wrap).
  - Hit:
    - If any overlap: the lowest index i wins; next cycle hit_o = (1<<i) for exactly one cycle.
    - score_o increments (saturating), bullet_active_o <= 0, state COOLDOWN.
  - Move: else if frame_i:
    - If bullet_top_o < top_limit_p + speed_p: miss_o pulses one cycle; go IDLE.
    - Otherwise bullet_top_o -= speed_p.
  - A collision and frame_i in the same cycle: collision wins and position is not updated.
  - fire_rise is ignored (no queueing).
- State COOLDOWN:
  - On entry the counter is cleared; it increments on each frame_i.
  - When count == cooldown_frames_p - 1 and frame_i: go IDLE.
  - fire ignored.
  - cooldown_frames_p = 0 means return to IDLE on the next cycle.
- Latency:
  - fire_rise to bullet_active_o = 1 cycle.
  - Overlap to hit_o = 1 cycle.
  - hit_o, miss_o and score_o are all registered.
- An enemy marking dead on the cycle of overlap is not hit; dead status is sampled combinationally.
- Encoded states: IDLE, FLYING, COOLDOWN; illegal encodings return to IDLE.

Test Plan:
- Launch and climb: player_left=300, player_top=440, fire rise:
  - Cycle after: bullet_active=1, left=300, top=432.
  - After 3 frame_i pulses: top=408.
  - Holding fire high produces no second launch.
- Miss: launch from top=40, no enemies overlapping (all dead):
  - Tops go 32, 24, 16, 8, 0.
  - Next frame_i: miss_o pulses once, active=0, score stays 0.
- Hit with priority: enemies 1 and 2 both at box x 296..336, y 100..110, both alive, bullet climbing from 432:
  - First overlap is at top=104 (bullet y 104..111).
  - hit_o=4'b0010 for exactly one cycle; score=1; active=0.
  - Repeat with enemy 1 dead: hit_o=4'b0100.
- Cooldown: after a hit with cooldown_frames_p=30:
  - fire rises at frames 5 and 29: ignored.
  - After the 30th frame_i the state is IDLE and the next fire rise launches.
- Simultaneous frame and hit: overlap asserted in the same cycle as frame_i → hit_o pulses and bullet_top is unchanged (no extra -8).
- Async reset mid-flight: drop reset_ni between clock edges at top=200 → outputs 0 immediately, no hit/miss pulse; after release, the first fire rise launches normally; score=0.
